// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, state encodings and helpers for the memory controller
package mem_ctrl_pkg;

    localparam int ADDR_WID = 32;
    localparam int DATA_WID = 32;

    typedef enum logic [2:0] {
        MC_IDLE   = 3'd0,
        MC_LSB_RD = 3'd1,
        MC_LSB_WR = 3'd2,
        MC_IF_RD  = 3'd3,
        MC_DONE   = 3'd4
    } mc_state_t;

    typedef enum logic [2:0] {
        LEN_BYTE = 3'd1,
        LEN_HALF = 3'd2,
        LEN_WORD = 3'd4
    } mc_len_t;

    // IO space is decoded from address bits [17:16] only.
    function automatic logic is_io_addr(input logic [1:0] addr_17_16);
        return addr_17_16 == 2'b11;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller serving the LSB and instruction-fetch requesters
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int CNT_WID    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    lsb_en,
    input  logic                    lsb_wr,
    input  logic [ADDR_WID-1:0]     lsb_addr,
    input  logic [2:0]              lsb_len,
    input  logic [DATA_WID-1:0]     lsb_w_data,
    output logic                    lsb_done,
    output logic [DATA_WID-1:0]     lsb_r_data,
    input  logic                    if_en,
    input  logic [ADDR_WID-1:0]     if_addr,
    output logic                    if_done,
    output logic [8*LINE_BYTES-1:0] if_data,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WID-1:0]     mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    localparam int LANE_WID = $clog2(LINE_BYTES);
    localparam logic [CNT_WID-1:0] CNT_ONE = CNT_WID'(1);

    mc_state_t            state, state_next;
    logic [CNT_WID-1:0]   cnt, len;
    logic [ADDR_WID-1:0]  base;
    logic [DATA_WID-1:0]  wdata;
    logic                 stall, last_wr, last_rd, accept_if;
    logic [1:0]           lsb_lane;
    logic [LANE_WID-1:0]  if_lane;

    assign accept_if = !lsb_en && if_en && !rollback;
    assign last_wr   = cnt == len - CNT_ONE;
    assign last_rd   = cnt == len;
    // Read data lags the address by one cycle, so the lane written is cnt-1.
    assign lsb_lane  = 2'(cnt - CNT_ONE);
    assign if_lane   = LANE_WID'(cnt - CNT_ONE);

    always_comb begin
        state_next = state;
        mem_a      = '0;
        mem_dout   = '0;
        stall      = 1'b0;
        case (state)
            MC_IDLE: begin
                if (lsb_en)
                    state_next = lsb_wr ? MC_LSB_WR : MC_LSB_RD;
                else if (accept_if)
                    state_next = MC_IF_RD;
            end
            MC_LSB_RD: begin
                mem_a    = base + ADDR_WID'(cnt[2:0]);
                mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                if (last_rd)
                    state_next = MC_DONE;
            end
            MC_LSB_WR: begin
                mem_a    = base + ADDR_WID'(cnt[2:0]);
                mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                stall    = io_buffer_full && is_io_addr(mem_a[17:16]);
                if (!stall && last_wr)
                    state_next = MC_DONE;
            end
            MC_IF_RD: begin
                mem_a = base + ADDR_WID'(cnt);
                if (rollback)
                    state_next = MC_IDLE;
                else if (last_rd)
                    state_next = MC_DONE;
            end
            MC_DONE:  state_next = MC_IDLE;
            default:  state_next = MC_IDLE;
        endcase
        mem_wr = rdy && (state == MC_LSB_WR) && !stall;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= MC_IDLE;
        else if (rdy)
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            len        <= '0;
            base       <= '0;
            wdata      <= '0;
            lsb_done   <= 1'b0;
            if_done    <= 1'b0;
            lsb_r_data <= '0;
            if_data    <= '0;
        end else if (rdy) begin
            lsb_done <= 1'b0;
            if_done  <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (lsb_en) begin
                        base  <= lsb_addr;
                        len   <= CNT_WID'(lsb_len);
                        wdata <= lsb_w_data;
                        cnt   <= '0;
                        if (!lsb_wr)
                            lsb_r_data <= '0;
                    end else if (accept_if) begin
                        base <= if_addr;
                        len  <= CNT_WID'(LINE_BYTES);
                        cnt  <= '0;
                    end
                end
                MC_LSB_WR: begin
                    if (!stall) begin
                        if (last_wr)
                            lsb_done <= 1'b1;
                        else
                            cnt <= cnt + CNT_ONE;
                    end
                end
                MC_LSB_RD: begin
                    if (cnt != '0)
                        lsb_r_data[{lsb_lane, 3'b000} +: 8] <= mem_din;
                    if (last_rd)
                        lsb_done <= 1'b1;
                    else
                        cnt <= cnt + CNT_ONE;
                end
                MC_IF_RD: begin
                    if (!rollback) begin
                        if (cnt != '0)
                            if_data[{if_lane, 3'b000} +: 8] <= mem_din;
                        if (last_rd)
                            if_done <= 1'b1;
                        else
                            cnt <= cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed vector bench for mem_ctrl against a synchronous byte RAM model
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst, rdy, rollback;
    logic         lsb_en, lsb_wr;
    logic [31:0]  lsb_addr;
    logic [2:0]   lsb_len;
    logic [31:0]  lsb_w_data;
    logic         lsb_done;
    logic [31:0]  lsb_r_data;
    logic         if_en;
    logic [31:0]  if_addr;
    logic         if_done;
    logic [127:0] if_data;
    logic [7:0]   mem_din = 8'h00;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic         io_buffer_full;

    mem_ctrl #(.LINE_BYTES(16), .CNT_WID(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
        .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:1023];
    int         wr_log = 0;

    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
            wr_log <= wr_log + 1;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    function automatic logic [7:0] init_byte(input int a);
        return a[7:0] ^ 8'h5A;
    endfunction

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lsb(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                          input logic [31:0] wd, input logic rb,
                          output logic [31:0] rd, output int lat, output logic [31:0] a1);
        lsb_en = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_len = len; lsb_w_data = wd;
        tick();
        rollback = rb;
        lat = -1;
        a1 = 32'hxxxxxxxx;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) a1 = mem_a;
            if (lsb_done) begin
                lat = c;
                break;
            end
        end
        rd = lsb_r_data;
        tick();
        lsb_en = 1'b0;
        rollback = 1'b0;
        check("done_clears", lsb_done, 0);
        check("no_repeat_idle", mem_a, 0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [31:0] exp_a1;
    } vec_t;

    vec_t         vecs [9];
    logic [31:0]  rd, a1, a15;
    int           lat, log0;
    logic [127:0] exp_line;
    logic         seen;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = init_byte(i);
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;

        vecs[0] = '{1'b0, 32'h100, LEN_WORD, 32'h0, 32'h44332211, 5, 32'h101};
        vecs[1] = '{1'b1, 32'h2A0, LEN_HALF, 32'hDEADBEEF, 32'h0, 2, 32'h2A1};
        vecs[2] = '{1'b0, 32'h2A0, LEN_WORD, 32'h0, 32'hF9F8BEEF, 5, 32'h2A1};
        vecs[3] = '{1'b0, 32'h105, LEN_BYTE, 32'h0, 32'h0000005F, 2, 32'h106};
        vecs[4] = '{1'b1, 32'h200, LEN_WORD, 32'h0A0B0C0D, 32'h0, 4, 32'h201};
        vecs[5] = '{1'b0, 32'h200, LEN_WORD, 32'h0, 32'h0A0B0C0D, 5, 32'h201};
        vecs[6] = '{1'b1, 32'h201, LEN_BYTE, 32'h000000EE, 32'h0, 1, 32'h0};
        vecs[7] = '{1'b0, 32'h200, LEN_WORD, 32'h0, 32'h0A0BEE0D, 5, 32'h201};
        vecs[8] = '{1'b0, 32'hFFFFFFFF, LEN_HALF, 32'h0, 32'h00005AA5, 3, 32'h0};

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_w_data = '0;
        if_en = 1'b0; if_addr = '0;
        repeat (3) tick();
        check("rst_lsb_done", lsb_done, 0);
        check("rst_if_done", if_done, 0);
        check("rst_lsb_r_data", lsb_r_data, 0);
        check("rst_if_data", if_data, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_dout", mem_dout, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            do_lsb(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wd, 1'b0, rd, lat, a1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_mem_a_cycle1", i), a1, vecs[i].exp_a1);
            if (!vecs[i].wr) check($sformatf("v%0d_r_data", i), rd, vecs[i].exp_rd);
        end

        // IO write back-pressure: three stalled cycles, then one write
        log0 = wr_log;
        io_buffer_full = 1'b1;
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = LEN_BYTE; lsb_w_data = 32'h77;
        tick();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall_wr_c%0d", c), mem_wr, 0);
            check($sformatf("stall_a_c%0d", c), mem_a, 32'h30000);
            tick();
        end
        io_buffer_full = 1'b0;
        #1;
        check("stall_release_wr", mem_wr, 1);
        check("stall_release_dout", mem_dout, 8'h77);
        check("stall_release_done", lsb_done, 0);
        tick();
        check("stall_done_c4", lsb_done, 1);
        check("stall_write_count", wr_log - log0, 1);
        tick();
        lsb_en = 1'b0;

        // rdy low holds everything for two cycles
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h220; lsb_len = LEN_HALF; lsb_w_data = 32'h5566;
        tick();
        rdy = 1'b0;
        #1;
        check("rdy_low_wr0", mem_wr, 0);
        tick();
        check("rdy_low_wr1", mem_wr, 0);
        check("rdy_low_a", mem_a, 32'h220);
        tick();
        rdy = 1'b1;
        lat = -1;
        for (int c = 3; c <= 40; c++) begin
            tick();
            if (lsb_done) begin
                lat = c;
                break;
            end
        end
        check("rdy_latency", lat, 4);
        tick();
        lsb_en = 1'b0;
        do_lsb(1'b0, 32'h220, LEN_HALF, 32'h0, 1'b0, rd, lat, a1);
        check("rdy_readback", rd, 32'h00005566);

        // Arbitration: LSB first, then the line fetch
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = LEN_BYTE;
        if_en = 1'b1; if_addr = 32'h40;
        tick();
        check("arb_lsb_first", mem_a, 32'h100);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (lsb_done) begin
                lat = c;
                break;
            end
        end
        check("arb_lsb_latency", lat, 2);
        check("arb_lsb_data", lsb_r_data, 32'h11);
        check("arb_if_not_done", if_done, 0);
        tick();
        lsb_en = 1'b0;
        tick();
        check("arb_fetch_start", mem_a, 32'h40);
        lat = -1;
        a15 = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 15) a15 = mem_a;
            if (if_done) begin
                lat = c;
                break;
            end
        end
        if_en = 1'b0;
        for (int i = 0; i < 16; i++) exp_line[8*i +: 8] = init_byte(32'h40 + i);
        check("fetch_latency", lat, 17);
        check("fetch_a_cycle15", a15, 32'h4F);
        check("fetch_line", if_data, exp_line);
        check("fetch_byte0", if_data[7:0], 8'h1A);
        tick();
        check("fetch_done_clears", if_done, 0);

        // Rollback during a fetch
        if_en = 1'b1; if_addr = 32'h80;
        tick();
        repeat (6) tick();
        check("rb_fetch_byte6", mem_a, 32'h86);
        rollback = 1'b1;
        tick();
        check("rb_mem_a_zero", mem_a, 0);
        check("rb_no_if_done", if_done, 0);
        tick();
        check("rb_if_ignored", mem_a, 0);
        rollback = 1'b0;
        if_en = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (if_done) seen = 1'b1;
        end
        check("rb_if_done_never", seen, 0);

        // Rollback does not abort an LSB read
        do_lsb(1'b0, 32'h100, LEN_WORD, 32'h0, 1'b1, rd, lat, a1);
        check("rb_lsb_latency", lat, 5);
        check("rb_lsb_data", rd, 32'h44332211);

        // Reset in the middle of a 4-byte write, after byte 1
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h300; lsb_len = LEN_WORD; lsb_w_data = 32'h11223344;
        tick();
        tick();
        check("mid_byte1_a", mem_a, 32'h301);
        rst = 1'b1;
        lsb_en = 1'b0;
        tick();
        check("mid_rst_wr", mem_wr, 0);
        check("mid_rst_done", lsb_done, 0);
        check("mid_rst_a", mem_a, 0);
        check("mid_rst_r_data", lsb_r_data, 0);
        rst = 1'b0;
        tick();
        do_lsb(1'b0, 32'h300, LEN_WORD, 32'h0, 1'b0, rd, lat, a1);
        check("post_rst_latency", lat, 5);
        check("post_rst_data", rd, 32'h59583344);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
